encode_arbiter: RTL and testbench

Round-robin arbiter that shares the team's single 8-input priority-encode/7-segment display path among eight requesters. It picks one active request line, holds a registered one-hot grant plus its 3-bit index until the requester releases or a hold timeout expires, then inserts one idle gap cycle before the next arbitration. The grant index drives the encoder's `y` display path downstream. Status bits mirror the encoder's LED conventions.

---
 rtl/encode_arbiter.sv | 120 ++++++++++++
 tb/tb_encode_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/encode_arbiter.sv
// encode_arbiter: round-robin arbiter sharing one 8-input priority-encode /
// 7-segment display path among eight requesters.
// Registered one-hot grant plus index, hold timeout, one-cycle GAP between
// grants.
// Optional build macro: ENCODE_ARB_FIXED_PRIO_EN selects highest-index-wins
// instead of round-robin.
module encode_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [4:0] led
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state, state_nx;
  logic [7:0] gnt_nx;
  logic [2:0] idx_nx;
  logic [2:0] ptr, ptr_nx;
  logic [7:0] hold, hold_nx;
  logic       to_nx;
  logic [2:0] win;
  logic [2:0] cand;
  logic       found;
  logic       release_req;
  logic [7:0] hold_last;

  assign hold_last = 8'(HOLD_MAX - 1);
  assign gnt_valid = |gnt;

  // Winner selection among the current request lines
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
`ifdef ENCODE_ARB_FIXED_PRIO_EN
    // Ascending scan: the last set bit seen is the highest index
    for (int unsigned i = 0; i < 8; i++) begin
      cand = 3'(i);
      if (req[cand]) win = cand;
    end
`else
    // Scan starting at ptr, wrapping from 7 back to 0
    for (int unsigned k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
`endif
  end

  // Next-state and next-register logic for the IDLE/GRANT/GAP sequence
  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    idx_nx      = gnt_idx;
    ptr_nx      = ptr;
    hold_nx     = hold;
    to_nx       = 1'b0;
    release_req = done || !req[gnt_idx] || !en;
    case (state)
      IDLE: begin
        if (en && (|req)) begin
          gnt_nx   = 8'b1 << win;
          idx_nx   = win;
          hold_nx  = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        hold_nx = hold + 8'd1;
        if (release_req || (hold == hold_last)) begin
          state_nx = GAP;
          gnt_nx   = '0;
          ptr_nx   = gnt_idx + 3'd1;
          // Timeout only when no other release cause is present this cycle
          to_nx    = !release_req;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
      hold    <= '0;
      timeout <= 1'b0;
      led     <= '0;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      gnt_idx <= idx_nx;
      ptr     <= ptr_nx;
      hold    <= hold_nx;
      timeout <= to_nx;
      led     <= {en, |req, gnt_idx};
    end
  end

endmodule

// File: tb/tb_encode_arbiter.sv
// Self-checking bench for encode_arbiter: driver steps a behavioural model and
// queues the expected post-edge outputs; a monitor pops and compares them.
module tb_encode_arbiter;
  localparam int unsigned HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic [4:0] led;

  int checks = 0;
  int failures = 0;

  encode_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
    .timeout(timeout), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
    logic [4:0] led;
  } exp_t;

  exp_t sb[$];

  // Behavioural model: owner = current holder (-1 none), held = cycles of
  // the current grant already completed, start = first index tried next.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 0;
  int m_start = 0;
  bit m_gap   = 0;
  bit m_to    = 0;
  int m_led   = 0;

  function automatic int pick(input logic [7:0] r, input int start);
    int w;
    w = -1;
`ifdef ENCODE_ARB_FIXED_PRIO_EN
    for (int i = 7; i >= 0; i--)
      if (w < 0 && r[i]) w = i;
`else
    for (int k = 0; k < 8; k++)
      if (w < 0 && r[(start + k) % 8]) w = (start + k) % 8;
`endif
    return w;
  endfunction

  task automatic model_step();
    bit other;
    if (rst) begin
      m_owner = -1; m_held = 0; m_last = 0; m_start = 0;
      m_gap = 0; m_to = 0; m_led = 0;
    end else begin
      m_to  = 0;
      m_led = (int'(en) << 4) | (int'(req != 0) << 3) | m_last;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_owner >= 0) begin
        other = done || !req[m_owner] || !en;
        if (other || (m_held + 1 == HOLD_MAX)) begin
          m_to    = !other;
          m_start = (m_owner + 1) % 8;
          m_owner = -1;
          m_gap   = 1;
        end else begin
          m_held++;
        end
      end else if (en && req != 0) begin
        m_owner = pick(req, m_start);
        m_last  = m_owner;
        m_held  = 0;
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input logic [7:0] q, input bit d);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; req = q; done = d;
    model_step();
    x.gnt   = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
    x.idx   = 3'(m_last);
    x.valid = (m_owner >= 0);
    x.to    = m_to;
    x.led   = 5'(m_led);
    sb.push_back(x);
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_valid} !== {x.gnt, x.idx, x.valid}) begin
        failures++;
        $display("FAIL grant t=%0t gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
                 $time, gnt, gnt_idx, gnt_valid, x.gnt, x.idx, x.valid);
      end
      checks++;
      if (timeout !== x.to) begin
        failures++;
        $display("FAIL timeout t=%0t got=%b expected=%b", $time, timeout, x.to);
      end
      checks++;
      if (led !== x.led) begin
        failures++;
        $display("FAIL led t=%0t got=%b expected=%b", $time, led, x.led);
      end
    end
  end

  initial begin
    logic [7:0] q;
    // Reset
    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);

    // Basic grant and release by done
    drive(0, 1, 8'h04, 0);
    drive(0, 1, 8'h04, 0);
    drive(0, 1, 8'h04, 1);
    drive(0, 1, 8'h00, 0);
    drive(0, 1, 8'h00, 0);

    // Rotation with all requests held, done pulsed once per grant
    for (int i = 0; i < 40; i++)
      drive(0, 1, 8'hFF, m_owner >= 0);

    // Timeout with a single held request
    for (int i = 0; i < 16; i++)
      drive(0, 1, 8'h01, 0);

    // done coinciding with the last allowed hold cycle
    for (int i = 0; i < 16; i++)
      drive(0, 1, 8'h01, (m_owner >= 0) && (m_held == HOLD_MAX - 1));

    // en dropped mid-grant, then held low with requests pending
    drive(0, 1, 8'h0A, 0);
    drive(0, 1, 8'h0A, 0);
    drive(0, 0, 8'h0A, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 8'h0A, 0);
    // Holder's request dropped mid-grant
    drive(0, 1, 8'h80, 0);
    drive(0, 1, 8'h80, 0);
    drive(0, 1, 8'h00, 0);
    drive(0, 1, 8'h00, 0);
    drive(0, 1, 8'h00, 0);

    // Reset while index 5 holds the grant, then all requesters
    for (int i = 0; i < 6 && m_owner != 5; i++) drive(0, 1, 8'h20, 0);
    drive(1, 1, 8'hFF, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 8'hFF, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: q = 8'($urandom);
        1: q = 8'b1 << $urandom_range(0, 7);
        2: q = (m_owner >= 0) ? (8'($urandom) | (8'b1 << m_owner)) : 8'($urandom);
        default: q = 8'h00;
      endcase
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, q,
            $urandom_range(0, 4) == 0);
    end
    drive(0, 0, 8'h00, 0);

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
